// File: rtl/cu_pkg.sv
// Shared encodings for the control unit: state names, opcodes, ALU
// operation codes, strobe bit positions and a small opcode classifier.
package cu_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_t;

  // Instruction families that share the same execute-phase strobe pattern
  typedef enum logic [2:0] {
    CL_NOP,
    CL_LDI,
    CL_LD,
    CL_ST,
    CL_ALU,
    CL_IMM,
    CL_BR,
    CL_HALT
  } class_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;

  localparam int CTL_W         = 28;
  localparam int CTL_PCOUT     = 0;
  localparam int CTL_ZHIGHOUT  = 1;
  localparam int CTL_ZLOWOUT   = 2;
  localparam int CTL_MDROUT    = 3;
  localparam int CTL_HIOUT     = 4;
  localparam int CTL_LOOUT     = 5;
  localparam int CTL_INPORTOUT = 6;
  localparam int CTL_COUT      = 7;
  localparam int CTL_BAOUT     = 8;
  localparam int CTL_ROUT      = 9;
  localparam int CTL_GRA       = 10;
  localparam int CTL_GRB       = 11;
  localparam int CTL_GRC       = 12;
  localparam int CTL_RIN       = 13;
  localparam int CTL_MARIN     = 14;
  localparam int CTL_MDRIN     = 15;
  localparam int CTL_PCIN      = 16;
  localparam int CTL_IRIN      = 17;
  localparam int CTL_YIN       = 18;
  localparam int CTL_ZLOWIN    = 19;
  localparam int CTL_ZHIGHIN   = 20;
  localparam int CTL_HIIN      = 21;
  localparam int CTL_LOIN      = 22;
  localparam int CTL_INCPC     = 23;
  localparam int CTL_READ      = 24;
  localparam int CTL_WRITE     = 25;
  localparam int CTL_CONIN     = 26;
  localparam int CTL_OUTPORTIN = 27;

  // Undefined opcodes fall into the nop family so they simply refetch
  function automatic class_t decodeClass(input logic [4:0] op);
    case (op)
      OP_LDI:                        return CL_LDI;
      OP_LD:                         return CL_LD;
      OP_ST:                         return CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR: return CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:      return CL_IMM;
      OP_BR:                         return CL_BR;
      OP_HALT:                       return CL_HALT;
      default:                       return CL_NOP;
    endcase
  endfunction

  // Address arithmetic (loads, stores, branches) always uses ADD
  function automatic logic [3:0] aluCode(input logic [4:0] op);
    case (op)
      OP_LDI, OP_LD, OP_ST, OP_ADD, OP_ADDI, OP_BR: return ALU_ADD;
      OP_SUB:                                       return ALU_SUB;
      OP_AND, OP_ANDI:                              return ALU_AND;
      OP_OR, OP_ORI:                                return ALU_OR;
      default:                                      return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control unit: steps through fetch (T0-T2) and the
// opcode-specific execute states, driving datapath strobes each state.
// State advances on the falling clock edge so strobes are settled by the
// datapath's rising edge.
module control_unit
  import cu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             stop,
  output logic [CTL_W-1:0] ctl,
  output logic [1:0]       mdr_read,
  output logic [3:0]       control,
  output logic             run
);

  state_t           r_state;
  state_t           w_nextState;
  state_t           w_lastState;
  class_t           w_class;
  logic [3:0]       w_alu;
  logic             w_atEnd;
  logic [26:0]      w_unusedIrBits;
  logic [CTL_W-1:0] w_ctl;
  logic [1:0]       w_mdrRead;
  logic [3:0]       w_control;
  logic             w_run;

  assign w_class        = decodeClass(ir[31:27]);
  assign w_alu          = aluCode(ir[31:27]);
  assign w_unusedIrBits = ir[26:0];
  assign w_atEnd        = (r_state == w_lastState);

  // Final state of the current instruction, where stop is honoured
  always_comb begin
    w_lastState = S_T2;
    case (w_class)
      CL_LDI, CL_ALU, CL_IMM: w_lastState = S_T5;
      CL_LD, CL_ST:           w_lastState = S_T7;
      CL_BR:                  w_lastState = S_T6;
      default:                w_lastState = S_T2;
    endcase
  end

  // State register on the falling edge, reset wins from any state
  always_ff @(negedge clk) begin
    if (reset) r_state <= S_RESET;
    else       r_state <= w_nextState;
  end

  // Sequencing: fetch, execute until the family's last state, then refetch or halt
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_RESET: w_nextState = S_T0;
      S_HALT:  w_nextState = S_HALT;
      default: begin
        if (r_state == S_T2 && w_class == CL_HALT) begin
          w_nextState = S_HALT;
        end else if (w_atEnd) begin
          w_nextState = stop ? S_HALT : S_T0;
        end else begin
          case (r_state)
            S_T0:    w_nextState = S_T1;
            S_T1:    w_nextState = S_T2;
            S_T2:    w_nextState = S_T3;
            S_T3:    w_nextState = S_T4;
            S_T4:    w_nextState = S_T5;
            S_T5:    w_nextState = S_T6;
            S_T6:    w_nextState = S_T7;
            default: w_nextState = S_T0;
          endcase
        end
      end
    endcase
  end

  // Strobe decoder from state and instruction family; con_ff only gates branch PCin
  always_comb begin
    w_ctl     = '0;
    w_mdrRead = 2'b00;
    w_control = ALU_NONE;
    w_run     = 1'b1;
    case (r_state)
      S_T0: begin
        w_ctl[CTL_PCOUT]  = 1'b1;
        w_ctl[CTL_MARIN]  = 1'b1;
        w_ctl[CTL_INCPC]  = 1'b1;
        w_ctl[CTL_ZLOWIN] = 1'b1;
      end
      S_T1: begin
        w_ctl[CTL_ZLOWOUT] = 1'b1;
        w_ctl[CTL_PCIN]    = 1'b1;
        w_ctl[CTL_READ]    = 1'b1;
        w_ctl[CTL_MDRIN]   = 1'b1;
        w_mdrRead          = 2'b01;
      end
      S_T2: begin
        w_ctl[CTL_MDROUT] = 1'b1;
        w_ctl[CTL_IRIN]   = 1'b1;
      end
      S_T3: begin
        case (w_class)
          CL_LDI, CL_LD, CL_ST: begin
            w_ctl[CTL_GRB]   = 1'b1;
            w_ctl[CTL_BAOUT] = 1'b1;
            w_ctl[CTL_YIN]   = 1'b1;
          end
          CL_ALU, CL_IMM: begin
            w_ctl[CTL_GRB]  = 1'b1;
            w_ctl[CTL_ROUT] = 1'b1;
            w_ctl[CTL_YIN]  = 1'b1;
          end
          CL_BR: begin
            w_ctl[CTL_GRA]   = 1'b1;
            w_ctl[CTL_ROUT]  = 1'b1;
            w_ctl[CTL_CONIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (w_class)
          CL_LDI, CL_LD, CL_ST, CL_IMM: begin
            w_ctl[CTL_COUT]   = 1'b1;
            w_ctl[CTL_ZLOWIN] = 1'b1;
            w_control         = w_alu;
          end
          CL_ALU: begin
            w_ctl[CTL_GRC]    = 1'b1;
            w_ctl[CTL_ROUT]   = 1'b1;
            w_ctl[CTL_ZLOWIN] = 1'b1;
            w_control         = w_alu;
          end
          CL_BR: begin
            w_ctl[CTL_PCOUT] = 1'b1;
            w_ctl[CTL_YIN]   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (w_class)
          CL_LDI, CL_ALU, CL_IMM: begin
            w_ctl[CTL_ZLOWOUT] = 1'b1;
            w_ctl[CTL_GRA]     = 1'b1;
            w_ctl[CTL_RIN]     = 1'b1;
          end
          CL_LD, CL_ST: begin
            w_ctl[CTL_ZLOWOUT] = 1'b1;
            w_ctl[CTL_MARIN]   = 1'b1;
          end
          CL_BR: begin
            w_ctl[CTL_COUT]   = 1'b1;
            w_ctl[CTL_ZLOWIN] = 1'b1;
            w_control         = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (w_class)
          CL_LD: begin
            w_ctl[CTL_READ]  = 1'b1;
            w_ctl[CTL_MDRIN] = 1'b1;
            w_mdrRead        = 2'b01;
          end
          CL_ST: begin
            w_ctl[CTL_GRA]   = 1'b1;
            w_ctl[CTL_ROUT]  = 1'b1;
            w_ctl[CTL_MDRIN] = 1'b1;
          end
          CL_BR: begin
            w_ctl[CTL_ZLOWOUT] = 1'b1;
            w_ctl[CTL_PCIN]    = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (w_class)
          CL_LD: begin
            w_ctl[CTL_MDROUT] = 1'b1;
            w_ctl[CTL_GRA]    = 1'b1;
            w_ctl[CTL_RIN]    = 1'b1;
          end
          CL_ST: begin
            w_ctl[CTL_WRITE] = 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        w_run = 1'b0;
      end
    endcase
  end

  assign ctl      = w_ctl;
  assign mdr_read = w_mdrRead;
  assign control  = w_control;
  assign run      = w_run;

endmodule

// File: tb/tb_control_unit.sv
// Randomised scoreboard bench for control_unit. A per-instruction strobe
// table model predicts what the unit shows in every cycle; the monitor
// compares each prediction at the rising edge.
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic [27:0] ctl;
  logic [1:0]  mdr_read;
  logic [3:0]  control;
  logic        run;

  control_unit dut (
    .clk      (clk),
    .reset    (reset),
    .ir       (ir),
    .con_ff   (con_ff),
    .stop     (stop),
    .ctl      (ctl),
    .mdr_read (mdr_read),
    .control  (control),
    .run      (run)
  );

  localparam int PCOUT = 0, ZLOWOUT = 2, MDROUT = 3, COUT = 7, BAOUT = 8;
  localparam int ROUT = 9, GRA = 10, GRB = 11, GRC = 12, RIN = 13;
  localparam int MARIN = 14, MDRIN = 15, PCIN = 16, IRIN = 17, YIN = 18;
  localparam int ZLOWIN = 19, INCPC = 23, READ = 24, WRITE = 25, CONIN = 26;

  localparam int M_RESET = 0, M_RUN = 1, M_HALT = 2;

  typedef struct packed {
    logic [27:0] ctl;
    logic [1:0]  mdr;
    logic [3:0]  alu;
    logic        run;
  } exp_t;

  typedef struct {
    logic [31:0] ir;
    logic        cf;
  } instr_t;

  exp_t        expQ[$];
  exp_t        mSteps[$];
  instr_t      pendQ[$];
  int          mMode;
  int          mIdx;
  logic [4:0]  mOp;
  logic [31:0] nextIr;
  logic        nextCf;
  logic        irPending;
  logic        rstLevel;
  logic        stopLevel;
  logic        allowHalt;
  int          compared;
  int          mismatched;
  int          cycleNo;

  // Free-running clock, first edge falling so reset is captured at once
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic logic [27:0] b(input int i);
    return 28'd1 << i;
  endfunction

  function automatic void addStep(input logic [27:0] c, input logic [1:0] m, input logic [3:0] a);
    exp_t e;
    e.ctl = c;
    e.mdr = m;
    e.alu = a;
    e.run = 1'b1;
    mSteps.push_back(e);
  endfunction

  // Whole-instruction strobe list, one entry per cycle starting at fetch
  function automatic void buildSteps(input logic [4:0] op, input logic cf);
    int a;
    mSteps.delete();
    addStep(b(PCOUT) | b(MARIN) | b(INCPC) | b(ZLOWIN), 2'b00, 4'd0);
    addStep(b(ZLOWOUT) | b(PCIN) | b(READ) | b(MDRIN), 2'b01, 4'd0);
    addStep(b(MDROUT) | b(IRIN), 2'b00, 4'd0);
    if (op == 5'd0 || op == 5'd1 || op == 5'd2) begin
      addStep(b(GRB) | b(BAOUT) | b(YIN), 2'b00, 4'd0);
      addStep(b(COUT) | b(ZLOWIN), 2'b00, 4'd2);
      if (op == 5'd1) begin
        addStep(b(ZLOWOUT) | b(GRA) | b(RIN), 2'b00, 4'd0);
      end else begin
        addStep(b(ZLOWOUT) | b(MARIN), 2'b00, 4'd0);
        if (op == 5'd0) begin
          addStep(b(READ) | b(MDRIN), 2'b01, 4'd0);
          addStep(b(MDROUT) | b(GRA) | b(RIN), 2'b00, 4'd0);
        end else begin
          addStep(b(GRA) | b(ROUT) | b(MDRIN), 2'b00, 4'd0);
          addStep(b(WRITE), 2'b00, 4'd0);
        end
      end
    end else if (op >= 5'd3 && op <= 5'd6) begin
      a = int'(op) - 1;
      addStep(b(GRB) | b(ROUT) | b(YIN), 2'b00, 4'd0);
      addStep(b(GRC) | b(ROUT) | b(ZLOWIN), 2'b00, 4'(a));
      addStep(b(ZLOWOUT) | b(GRA) | b(RIN), 2'b00, 4'd0);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      a = (op == 5'd12) ? 2 : (op == 5'd13) ? 4 : 5;
      addStep(b(GRB) | b(ROUT) | b(YIN), 2'b00, 4'd0);
      addStep(b(COUT) | b(ZLOWIN), 2'b00, 4'(a));
      addStep(b(ZLOWOUT) | b(GRA) | b(RIN), 2'b00, 4'd0);
    end else if (op == 5'd18) begin
      addStep(b(GRA) | b(ROUT) | b(CONIN), 2'b00, 4'd0);
      addStep(b(PCOUT) | b(YIN), 2'b00, 4'd0);
      addStep(b(COUT) | b(ZLOWIN), 2'b00, 4'd2);
      addStep(b(ZLOWOUT) | (cf ? b(PCIN) : 28'd0), 2'b00, 4'd0);
    end
  endfunction

  function automatic logic [4:0] randomOp();
    logic [4:0] op;
    case ($urandom_range(0, 15))
      0: op = 5'd0;   1: op = 5'd1;   2: op = 5'd2;   3: op = 5'd3;
      4: op = 5'd4;   5: op = 5'd5;   6: op = 5'd6;   7: op = 5'd12;
      8: op = 5'd13;  9: op = 5'd14;  10: op = 5'd18; 11: op = 5'd18;
      12: op = 5'd26; 13: op = 5'd27; 14: op = 5'd7;  default: op = 5'd31;
    endcase
    if (op == 5'd27 && !allowHalt) op = 5'd26;
    return op;
  endfunction

  // Begin the next instruction in the model; ir is applied once the unit is in T0
  function automatic void startInstr();
    instr_t t;
    if (pendQ.size() > 0) begin
      t = pendQ.pop_front();
    end else begin
      t.ir = {randomOp(), 27'($urandom)};
      t.cf = 1'($urandom_range(0, 1));
    end
    nextIr    = t.ir;
    nextCf    = t.cf;
    irPending = 1'b1;
    mOp       = t.ir[31:27];
    buildSteps(mOp, t.cf);
    mIdx  = 0;
    mMode = M_RUN;
  endfunction

  // One clock: predict the current state's outputs, drive inputs, advance the model
  task automatic applyStimulus();
    exp_t e;
    @(negedge clk);
    #1;
    cycleNo++;
    if (irPending) begin
      ir        = nextIr;
      con_ff    = nextCf;
      irPending = 1'b0;
    end
    if (mMode == M_RUN) e = mSteps[mIdx];
    else                e = '0;
    expQ.push_back(e);
    reset = rstLevel;
    stop  = stopLevel;
    if (rstLevel) begin
      mMode = M_RESET;
    end else if (mMode == M_RESET) begin
      startInstr();
    end else if (mMode == M_RUN) begin
      if (mIdx == mSteps.size() - 1) begin
        if (mOp == 5'd27 || stopLevel) mMode = M_HALT;
        else                           startInstr();
      end else begin
        mIdx++;
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t a;
    a = {ctl, mdr_read, control, run};
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("[TB] FAIL cycle%0d outputs: got ctl=%h mdr_read=%b control=%0d run=%b, expected ctl=%h mdr_read=%b control=%0d run=%b",
               cycleNo, a.ctl, a.mdr, a.alu, a.run, e.ctl, e.mdr, e.alu, e.run);
    end
    compared++;
    if (ctl[READ] === 1'b1 && ctl[WRITE] === 1'b1) begin
      mismatched++;
      $display("[TB] FAIL cycle%0d read_write_exclusive: got read=1 write=1, expected not both", cycleNo);
    end
  endtask

  // Monitor: compare every predicted cycle at the datapath's rising edge
  always @(posedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic drainPending();
    int guard;
    guard = 0;
    while (pendQ.size() > 0 && guard < 200) begin
      applyStimulus();
      guard++;
    end
    if (pendQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_pending: got %0d left, expected 0", pendQ.size());
    end
  endtask

  task automatic waitStep(input logic [4:0] op, input int idx);
    int guard;
    guard = 0;
    while (!(mMode == M_RUN && mOp == op && mIdx == idx) && guard < 100) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 100) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_step op=%0d idx=%0d: got timeout, expected reached", op, idx);
    end
  endtask

  task automatic pushInstr(input logic [31:0] w, input logic cf);
    instr_t t;
    t.ir = w;
    t.cf = cf;
    pendQ.push_back(t);
  endtask

  initial begin
    reset      = 1'b1;
    ir         = '0;
    con_ff     = 1'b0;
    stop       = 1'b0;
    rstLevel   = 1'b1;
    stopLevel  = 1'b0;
    allowHalt  = 1'b0;
    irPending  = 1'b0;
    mMode      = M_RESET;
    mIdx       = 0;
    mOp        = '0;
    compared   = 0;
    mismatched = 0;
    cycleNo    = 0;

    runCycles(2);
    pushInstr(32'h0880_0055, 1'b0);
    pushInstr(32'h1989_0000, 1'b0);
    pushInstr(32'h9080_0000, 1'b0);
    pushInstr(32'h9080_0000, 1'b1);
    pushInstr(32'h1080_0000, 1'b0);
    pushInstr(32'h0080_0010, 1'b0);
    pushInstr(32'hD000_0000, 1'b0);
    pushInstr(32'h4000_0000, 1'b0);
    pushInstr(32'h7000_0000, 1'b0);
    pushInstr(32'h2000_0000, 1'b0);
    pushInstr(32'h6800_0000, 1'b0);
    rstLevel = 1'b0;
    drainPending();
    runCycles(8);

    pushInstr(32'h0080_0000, 1'b0);
    waitStep(5'd0, 5);
    stopLevel = 1'b1;
    runCycles(8);
    stopLevel = 1'b0;
    rstLevel  = 1'b1;
    runCycles(1);
    rstLevel  = 1'b0;
    runCycles(10);

    pushInstr(32'hD800_0000, 1'b0);
    runCycles(14);
    rstLevel = 1'b1;
    runCycles(1);
    rstLevel = 1'b0;
    runCycles(10);

    pushInstr(32'h0080_0000, 1'b0);
    waitStep(5'd0, 4);
    rstLevel = 1'b1;
    runCycles(1);
    rstLevel = 1'b0;
    runCycles(12);

    allowHalt = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (mMode == M_HALT) rstLevel = ($urandom_range(0, 3) == 0);
      else                 rstLevel = ($urandom_range(0, 99) < 2);
      stopLevel = ($urandom_range(0, 99) < 4);
      applyStimulus();
    end

    @(posedge clk);
    #1;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all encodings SHALL come from package cu_pkg.
REQ-002 clk  input  1  single system clock; the state register SHALL advance on the falling edge so strobes are stable at the datapath's rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 ir  input  32  current IR contents from the datapath; opcode ir[31:27].
REQ-005 con_ff  input  1  branch condition flag from the datapath CON FF.
REQ-006 stop  input  1  request to halt at the next instruction boundary.
REQ-007 ctl  output  28  one-hot-per-signal datapath strobe bus; bit map in cu_pkg.
REQ-008 mdr_read  output  2  MDR input mux select: 00 bus, 01 memory.
REQ-009 control  output  4  ALU operation code.
REQ-010 run  output  1  high while executing; low in RESET and HALT.

Function
REQ-011 States SHALL be RESET, T0..T7 and HALT; outputs SHALL be Moore-decoded from state and ir (con_ff only in branch T6).
REQ-012 Fetch SHALL be: T0 PCout MARin IncPc Zlowin; T1 Zlowout PCin read MDRin mdr_read=01; T2 MDRout IRin.
REQ-013 ldi (00001): T3 GRB BAout Yin; T4 Cout control=ADD Zlowin; T5 Zlowout GRA Rin; then T0.
REQ-014 ld (00000): T3-T4 as ldi; T5 Zlowout MARin; T6 read MDRin mdr_read=01; T7 MDRout GRA Rin; then T0.
REQ-015 st (00010): T3-T5 as ld; T6 GRA Rout MDRin mdr_read=00; T7 write; then T0.
REQ-016 add/sub/and/or (00011..00110): T3 GRB Rout Yin; T4 GRC Rout Zlowin control=ADD/SUB/AND/OR; T5 Zlowout GRA Rin; then T0.
REQ-017 addi/andi/ori (01100..01110): T3 GRB Rout Yin; T4 Cout Zlowin control=ADD/AND/OR; T5 Zlowout GRA Rin; then T0.
REQ-018 br (10010): T3 GRA Rout CONin; T4 PCout Yin; T5 Cout control=ADD Zlowin; T6 Zlowout, plus PCin only if con_ff=1; then T0.
REQ-019 nop (11010) and every undefined opcode SHALL return T2->T0 with no further strobes.
REQ-020 halt (11011) SHALL go T2->HALT; HALT SHALL hold ctl=0, run=0 until reset.
REQ-021 stop=1 sampled on the falling edge ending an instruction's last state SHALL enter HALT instead of T0; stop mid-instruction SHALL NOT truncate it.
REQ-022 Strobes not listed for a state SHALL be 0; read and write SHALL never both be 1; control SHALL be 0 outside ALU states.
REQ-023 Cycle counts T0-to-T0: ldi/ALU/imm 6, ld/st 8, br 7, nop 3.

Reset
REQ-024 reset=1 at a falling edge SHALL enter RESET from any state, including mid-instruction; ctl=0, mdr_read=00, control=0, run=0.
REQ-025 First falling edge with reset=0 SHALL move RESET->T0 and set run=1.

Structure
REQ-026 cu_pkg SHALL hold the state enum, 5-bit opcodes, ALU codes (ADD=2, SUB=3, AND=4, OR=5) and CTL_* bit indices 0..27: PCout Zhighout Zlowout MDRout HIout LOout InPortout Cout BAout Rout GRA GRB GRC Rin MARin MDRin PCin IRin Yin Zlowin Zhighin HIin LOin IncPc read write CONin OutPortin.
REQ-027 Single module: next-state logic plus output decoder; no sub-module.

Verification
REQ-028 Reset 2 cycles, release, ir=0x08800055 (ldi r1,85) -> T0 ctl={PCout,MARin,IncPc,Zlowin}; T4 control=2; T5 {Zlowout,GRA,Rin}; T0 again 6 falling edges after the first T0.
REQ-029 ir=0x19890000 (add r3,r1,r2) -> T4 {GRC,Rout,Zlowin}, control=2; T5 {Zlowout,GRA,Rin}.
REQ-030 br with con_ff=0 -> T6 ctl={Zlowout}, PCin=0; repeat with con_ff=1 -> T6 PCin=1.
REQ-031 st -> T6 mdr_read=00, MDRin=1; T7 write=1, read=0; ld -> T6 read=1, mdr_read=01.
REQ-032 stop=1 during ld T5 -> T6, T7 complete, then HALT with run=0; opcode 11011 -> HALT after T2; reset recovers both.
REQ-033 reset=1 during ld T4 -> next falling edge ctl=0, run=0; release -> T0 fetch restarts.
